reg_file_2w2r: RTL and testbench
================================

Name: reg_file_2w2r

Overview:
- Parametrised successor to the 8x8 CPU register file: 2^ADDR_W registers of DATA_W bits, two read ports and two write ports.
- Read timing is selectable (asynchronous or registered). Optional write-to-read bypass and an optional hard-wired zero register.
- Sits between the instruction decoder/control unit (addresses, enables) and the ALU (operands) / writeback path (results) of the processor datapath.

Parameters:
- DATA_W, 8: register and data bus width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers.
- READ_REG, 0: 0 = combinational read; 1 = registered read, data valid one cycle after the address.
- BYPASS, 1: 1 = a read of an address being written this cycle returns the new data; 0 = returns the old contents.
- ZERO_REG0, 0: 1 = register 0 reads as 0 and ignores writes.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- WRITE1  in  1  write enable, port 1.
- INADDRESS1  in  ADDR_W  write address, port 1.
- IN1  in  DATA_W  write data, port 1.
- WRITE2  in  1  write enable, port 2.
- INADDRESS2  in  ADDR_W  write address, port 2.
- IN2  in  DATA_W  write data, port 2.
- OUT1ADDRESS  in  ADDR_W  read address, port 1.
- OUT2ADDRESS  in  ADDR_W  read address, port 2.
- OUT1  out  DATA_W  read data, port 1.
- OUT2  out  DATA_W  read data, port 2.
- CONFLICT  out  1  registered flag: the previous edge saw both write ports enabled on the same address.

Behaviour:
- Reset: reset RESET, synchronous, active-high; clock CLK. On a rising edge with RESET=1:
  - all registers <= 0, CONFLICT <= 0;
  - when READ_REG=1, OUT1/OUT2 <= 0.
  - RESET has priority over both writes in the same cycle: writes are dropped.
- Reset mid-operation: any write presented with RESET is lost. The first write after RESET deasserts is honoured normally.
- Write: on a rising edge, reg[INADDRESSn] <= INn when WRITEn=1. No internal #delays; commit is at the edge.
- Simultaneous writes, same address: port 2 wins. CONFLICT <= 1 for exactly that cycle, otherwise CONFLICT <= 0.
- Simultaneous writes, different addresses: both commit.
- ZERO_REG0=1: writes to address 0 are discarded and do not set CONFLICT. Reads of address 0 always return 0, including through bypass.
- Read with READ_REG=0: OUTn = reg[OUTnADDRESS] combinationally, zero latency.
  - With BYPASS=1 and a matching enabled write, OUTn shows that write's data (port 2 data if both match) in the same cycle.
  - With BYPASS=0, OUTn shows the old value until the edge, then the new value.
- Read with READ_REG=1: OUTn <= reg[OUTnADDRESS] at each rising edge, one-cycle latency.
  - With BYPASS=1, a same-edge write to that address is forwarded, so OUTn holds the newly written value.
  - With BYPASS=0, OUTn holds the pre-write value.
- Both read ports may address the same register, or the register being written; each is resolved independently.
- Addresses wrap naturally within ADDR_W. No out-of-range case exists.
- Signedness: storage is raw bits; no sign handling inside the block.
- X handling: WRITEn=0 makes INADDRESSn/INn don't-care. Outputs must not go X after reset.

Decomposition:
- Shared package (processor-wide defines file): DATA_W/ADDR_W defaults, a REG_ZERO address constant, and READ_REG mode constants (READ_COMB=0, READ_SYNC=1).
- One natural sub-module, reg_file_read_port. Instantiated twice, it takes:
  - the flat register array, the read address, and both write-port enables/addresses/data;
  - BYPASS/ZERO_REG0/READ_REG as parameters.
  - It returns the resolved read value, registered or not per READ_REG.
- The top level holds the storage array, write/priority logic and CONFLICT.

Test Plan:
- Reset then read (defaults, READ_REG=0): preload all regs with 8'hFF; assert RESET for 1 edge with WRITE1=1, INADDRESS1=2, IN1=95 -> all regs read 0, reg2 = 0 (write dropped), CONFLICT=0.
- Basic write/read, both modes: write reg2=95, reg4=6 on port 1 on successive edges; read OUT1ADDRESS=2, OUT2ADDRESS=4 -> 95/6 immediately when READ_REG=0, one edge later when READ_REG=1.
- Dual-write conflict: WRITE1=WRITE2=1, both to address 1, IN1=28, IN2=50 -> reg1=50, CONFLICT=1 for one cycle. Next cycle, writes to addresses 3/5 with 7/9 -> both commit, CONFLICT=0.
- Bypass: reg1 holds 28; write reg1=15 while OUT1ADDRESS=1.
  - BYPASS=1: OUT1=15 in the write cycle (READ_REG=0) or right after the edge (READ_REG=1).
  - BYPASS=0: OUT1=28 then 15 (READ_REG=0); registered OUT1=28 after the edge, 15 one edge later (READ_REG=1).
- Zero register (ZERO_REG0=1): write address 0 = 8'hAA on port 1 and address 0 = 8'h55 on port 2 -> OUT1 (address 0) = 0, including bypass, and CONFLICT=0.
- Width/depth sweep: DATA_W=16, ADDR_W=4. Write addr 15 = 16'hBEEF and addr 0 = 16'h1234, then random dual-port writes/reads for 1000 cycles against a reference model -> zero mismatches.

Source files
------------

// File: rtl/reg_file_2w2r_pkg.sv
// Processor-wide defines shared by the register file and its read ports.
// Holds default geometry, the hard-wired zero register address and read-mode constants.
package reg_file_2w2r_pkg;

  localparam int unsigned RF_DATA_W = 8;
  localparam int unsigned RF_ADDR_W = 3;

  localparam int unsigned REG_ZERO = 0;

  localparam bit READ_COMB = 1'b0;
  localparam bit READ_SYNC = 1'b1;

  // True when addr names the hard-wired zero register and that feature is enabled.
  function automatic bit is_zero_reg(input bit zero_en, input int unsigned addr);
    return zero_en && (addr == REG_ZERO);
  endfunction

endpackage : reg_file_2w2r_pkg

// File: rtl/reg_file_2w2r_if.sv
// Decoder/writeback/ALU-facing bus of the 2-write/2-read register file.
// master = datapath control side, slave = register file.
interface reg_file_2w2r_if
  import reg_file_2w2r_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
);

  logic              WRITE1;
  logic [ADDR_W-1:0] INADDRESS1;
  logic [DATA_W-1:0] IN1;
  logic              WRITE2;
  logic [ADDR_W-1:0] INADDRESS2;
  logic [DATA_W-1:0] IN2;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              CONFLICT;

  modport master (
    output WRITE1, INADDRESS1, IN1,
    output WRITE2, INADDRESS2, IN2,
    output OUT1ADDRESS, OUT2ADDRESS,
    input  OUT1, OUT2, CONFLICT
  );

  modport slave (
    input  WRITE1, INADDRESS1, IN1,
    input  WRITE2, INADDRESS2, IN2,
    input  OUT1ADDRESS, OUT2ADDRESS,
    output OUT1, OUT2, CONFLICT
  );

endinterface : reg_file_2w2r_if

// File: rtl/reg_file_read_port.sv
// One read port: selects a register, optionally forwards a same-cycle write,
// forces the zero register, and optionally registers the result.
module reg_file_read_port
  import reg_file_2w2r_pkg::*;
#(
  parameter int unsigned DATA_W    = RF_DATA_W,
  parameter int unsigned ADDR_W    = RF_ADDR_W,
  parameter bit          READ_REG  = READ_COMB,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          ZERO_REG0 = 1'b0
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs,
  input  logic [ADDR_W-1:0]                    raddr,
  input  logic                                 we1,
  input  logic [ADDR_W-1:0]                    waddr1,
  input  logic [DATA_W-1:0]                    wdata1,
  input  logic                                 we2,
  input  logic [ADDR_W-1:0]                    waddr2,
  input  logic [DATA_W-1:0]                    wdata2,
  output logic [DATA_W-1:0]                    rdata
);

  logic [DATA_W-1:0] resolved_c;
  logic [DATA_W-1:0] rdata_q;
  logic              fwd1_c;
  logic              fwd2_c;

  // A write presented with RESET never commits, so it must not be forwarded either.
  assign fwd1_c = BYPASS && !RESET && we1 && (waddr1 == raddr);
  assign fwd2_c = BYPASS && !RESET && we2 && (waddr2 == raddr);

  // Port 2 forwarding overrides port 1, matching write priority.
  always_comb begin
    resolved_c = regs[raddr];
    if (fwd1_c) begin
      resolved_c = wdata1;
    end
    if (fwd2_c) begin
      resolved_c = wdata2;
    end
    if (is_zero_reg(ZERO_REG0, 32'(raddr))) begin
      resolved_c = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= resolved_c;
    end
  end

  assign rdata = READ_REG ? rdata_q : resolved_c;

endmodule : reg_file_read_port

// File: rtl/reg_file_2w2r.sv
// Parametrised 2-write/2-read CPU register file: storage, write priority,
// same-address conflict flag, and two independent read ports.
module reg_file_2w2r
  import reg_file_2w2r_pkg::*;
#(
  parameter int unsigned DATA_W    = RF_DATA_W,
  parameter int unsigned ADDR_W    = RF_ADDR_W,
  parameter bit          READ_REG  = READ_COMB,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          ZERO_REG0 = 1'b0
) (
  input  logic            CLK,
  input  logic            RESET,
  reg_file_2w2r_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic                         conflict_q;
  logic                         we1_c;
  logic                         we2_c;
  logic                         same_addr_c;

  // Writes aimed at the hard-wired zero register are dropped before they reach anything.
  assign we1_c       = bus.WRITE1 && !is_zero_reg(ZERO_REG0, 32'(bus.INADDRESS1));
  assign we2_c       = bus.WRITE2 && !is_zero_reg(ZERO_REG0, 32'(bus.INADDRESS2));
  assign same_addr_c = (bus.INADDRESS1 == bus.INADDRESS2);

  // Port 2 is assigned last so it wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs       <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (we1_c) begin
        regs[bus.INADDRESS1] <= bus.IN1;
      end
      if (we2_c) begin
        regs[bus.INADDRESS2] <= bus.IN2;
      end
      conflict_q <= we1_c && we2_c && same_addr_c;
    end
  end

  assign bus.CONFLICT = conflict_q;

  reg_file_read_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .READ_REG  (READ_REG),
    .BYPASS    (BYPASS),
    .ZERO_REG0 (ZERO_REG0)
  ) u_rd1 (
    .CLK    (CLK),
    .RESET  (RESET),
    .regs   (regs),
    .raddr  (bus.OUT1ADDRESS),
    .we1    (we1_c),
    .waddr1 (bus.INADDRESS1),
    .wdata1 (bus.IN1),
    .we2    (we2_c),
    .waddr2 (bus.INADDRESS2),
    .wdata2 (bus.IN2),
    .rdata  (bus.OUT1)
  );

  reg_file_read_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .READ_REG  (READ_REG),
    .BYPASS    (BYPASS),
    .ZERO_REG0 (ZERO_REG0)
  ) u_rd2 (
    .CLK    (CLK),
    .RESET  (RESET),
    .regs   (regs),
    .raddr  (bus.OUT2ADDRESS),
    .we1    (we1_c),
    .waddr1 (bus.INADDRESS1),
    .wdata1 (bus.IN1),
    .we2    (we2_c),
    .waddr2 (bus.INADDRESS2),
    .wdata2 (bus.IN2),
    .rdata  (bus.OUT2)
  );

endmodule : reg_file_2w2r

// File: tb/tb_reg_file_2w2r.sv
// Bench for reg_file_2w2r: six configurations driven by one stimulus stream,
// checked against a register-array reference model, a vector table and hand sequences.
module tb_reg_file_2w2r;

  localparam int NDUT = 6;
  localparam int unsigned RR[NDUT] = '{0, 1, 0, 1, 0, 1};
  localparam int unsigned BP[NDUT] = '{1, 1, 0, 0, 1, 1};
  localparam int unsigned ZR[NDUT] = '{0, 0, 0, 0, 1, 0};
  localparam int unsigned DW[NDUT] = '{8, 8, 8, 8, 8, 16};
  localparam int unsigned AW[NDUT] = '{3, 3, 3, 3, 3, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        w1, w2;
  logic [3:0]  a1, a2, ra1, ra2;
  logic [15:0] d1, d2;

  logic [15:0] o1 [NDUT];
  logic [15:0] o2 [NDUT];
  logic        cf [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned GDW = DW[g];
    localparam int unsigned GAW = AW[g];
    reg_file_2w2r_if #(.DATA_W(GDW), .ADDR_W(GAW)) bus ();
    assign bus.WRITE1      = w1;
    assign bus.INADDRESS1  = GAW'(a1);
    assign bus.IN1         = GDW'(d1);
    assign bus.WRITE2      = w2;
    assign bus.INADDRESS2  = GAW'(a2);
    assign bus.IN2         = GDW'(d2);
    assign bus.OUT1ADDRESS = GAW'(ra1);
    assign bus.OUT2ADDRESS = GAW'(ra2);
    reg_file_2w2r #(
      .DATA_W    (GDW),
      .ADDR_W    (GAW),
      .READ_REG  (RR[g] != 0),
      .BYPASS    (BP[g] != 0),
      .ZERO_REG0 (ZR[g] != 0)
    ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
    );
    assign o1[g] = 16'(bus.OUT1);
    assign o2[g] = 16'(bus.OUT2);
    assign cf[g] = bus.CONFLICT;
  end

  // Reference model: plain register arrays plus the value each registered port should show next.
  logic [15:0] mem [NDUT][16];
  logic [15:0] er1 [NDUT];
  logic [15:0] er2 [NDUT];
  logic        ecf [NDUT];
  bit          skip_comb;
  int          n_chk  = 0;
  int          n_fail = 0;

  typedef struct {
    logic        rst, w1, w2, ecf;
    logic [3:0]  a1, a2, ra1, ra2;
    logic [15:0] d1, d2, e1, e2;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(int r, int we1, int ad1, int dd1, int we2, int ad2, int dd2,
                              int r1, int r2, int x1, int x2, int xc);
    vec_t v;
    v.rst = 1'(r);   v.w1 = 1'(we1); v.a1 = 4'(ad1); v.d1 = 16'(dd1);
    v.w2 = 1'(we2);  v.a2 = 4'(ad2); v.d2 = 16'(dd2);
    v.ra1 = 4'(r1);  v.ra2 = 4'(r2); v.e1 = 16'(x1); v.e2 = 16'(x2); v.ecf = 1'(xc);
    return v;
  endfunction

  task automatic apply(int r, int we1, int ad1, int dd1, int we2, int ad2, int dd2, int r1, int r2);
    rst = 1'(r); w1 = 1'(we1); a1 = 4'(ad1); d1 = 16'(dd1);
    w2 = 1'(we2); a2 = 4'(ad2); d2 = 16'(dd2); ra1 = 4'(r1); ra2 = 4'(r2);
  endtask

  task automatic check(string name, int k, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  function automatic logic [3:0] amask(int k);
    return 4'((1 << AW[k]) - 1);
  endfunction

  function automatic logic [15:0] dmask(int k);
    return 16'((32'd1 << DW[k]) - 1);
  endfunction

  function automatic bit wr_ok(int k, logic w, logic [3:0] a);
    return w && !(ZR[k] != 0 && (a & amask(k)) == 4'd0);
  endfunction

  // Value a read of ra should produce right now, under the configuration of dut k.
  function automatic logic [15:0] resolve(int k, logic [3:0] ra, bit bypass);
    logic [3:0] m;
    m = ra & amask(k);
    if (ZR[k] != 0 && m == 4'd0) return 16'd0;
    if (bypass && !rst) begin
      if (wr_ok(k, w2, a2) && (a2 & amask(k)) == m) return d2 & dmask(k);
      if (wr_ok(k, w1, a1) && (a1 & amask(k)) == m) return d1 & dmask(k);
    end
    return mem[k][m];
  endfunction

  // Before the edge: check combinational reads, then advance the model across the edge.
  task automatic pre_half();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (RR[k] == 0 && !skip_comb) begin
        check("comb_out1", k, o1[k], resolve(k, ra1, BP[k] != 0));
        check("comb_out2", k, o2[k], resolve(k, ra2, BP[k] != 0));
      end
      er1[k] = rst ? 16'd0 : resolve(k, ra1, BP[k] != 0);
      er2[k] = rst ? 16'd0 : resolve(k, ra2, BP[k] != 0);
      ecf[k] = !rst && wr_ok(k, w1, a1) && wr_ok(k, w2, a2) &&
               ((a1 & amask(k)) == (a2 & amask(k)));
      if (rst) begin
        for (int i = 0; i < 16; i++) mem[k][i] = 16'd0;
      end else begin
        if (wr_ok(k, w1, a1)) mem[k][a1 & amask(k)] = d1 & dmask(k);
        if (wr_ok(k, w2, a2)) mem[k][a2 & amask(k)] = d2 & dmask(k);
      end
    end
  endtask

  // After the edge: check CONFLICT and registered reads.
  task automatic post_half();
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("conflict", k, 16'(cf[k]), 16'(ecf[k]));
      if (RR[k] != 0) begin
        check("reg_out1", k, o1[k], er1[k]);
        check("reg_out2", k, o2[k], er2[k]);
      end
    end
  endtask

  task automatic cycle();
    pre_half();
    post_half();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Preload FF everywhere, reset with a dropped write, then basic/conflict/bypass traffic.
    tbl[0]  = mk(0, 1, 0, 'hFF, 1, 1, 'hFF, 0, 1, 'hFF, 'hFF, 0);
    tbl[1]  = mk(0, 1, 2, 'hFF, 1, 3, 'hFF, 0, 3, 'hFF, 'hFF, 0);
    tbl[2]  = mk(0, 1, 4, 'hFF, 1, 5, 'hFF, 4, 5, 'hFF, 'hFF, 0);
    tbl[3]  = mk(0, 1, 6, 'hFF, 1, 7, 'hFF, 7, 2, 'hFF, 'hFF, 0);
    tbl[4]  = mk(1, 1, 2, 95,   0, 0, 0,     2, 5, 'hFF, 'hFF, 0);
    tbl[5]  = mk(0, 0, 0, 0,    0, 0, 0,     2, 5, 0,    0,    0);
    tbl[6]  = mk(0, 1, 2, 95,   0, 0, 0,     2, 4, 95,   0,    0);
    tbl[7]  = mk(0, 1, 4, 6,    0, 0, 0,     2, 4, 95,   6,    0);
    tbl[8]  = mk(0, 0, 0, 0,    0, 0, 0,     2, 4, 95,   6,    0);
    tbl[9]  = mk(0, 1, 1, 28,   1, 1, 50,    1, 1, 50,   50,   1);
    tbl[10] = mk(0, 1, 3, 7,    1, 5, 9,     1, 3, 50,   7,    0);
    tbl[11] = mk(0, 0, 0, 0,    0, 0, 0,     3, 5, 7,    9,    0);
    tbl[12] = mk(0, 1, 1, 28,   0, 0, 0,     1, 1, 28,   28,   0);
    tbl[13] = mk(0, 1, 1, 15,   0, 0, 0,     1, 1, 15,   15,   0);
    tbl[14] = mk(0, 0, 0, 0,    0, 0, 0,     1, 0, 15,   0,    0);

    skip_comb = 1'b1;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    skip_comb = 1'b0;

    foreach (tbl[i]) begin
      apply(int'(tbl[i].rst), int'(tbl[i].w1), int'(tbl[i].a1), int'(tbl[i].d1),
            int'(tbl[i].w2), int'(tbl[i].a2), int'(tbl[i].d2), int'(tbl[i].ra1), int'(tbl[i].ra2));
      pre_half();
      check("tbl_out1", i, o1[0], tbl[i].e1);
      check("tbl_out2", i, o2[0], tbl[i].e2);
      post_half();
      check("tbl_conflict", i, 16'(cf[0]), 16'(tbl[i].ecf));
    end

    // Bypass on/off, both read modes: reg1 = 28, then overwrite with 15 while reading it.
    apply(0, 1, 1, 28, 0, 0, 0, 1, 1);
    cycle();
    apply(0, 1, 1, 15, 0, 0, 0, 1, 1);
    pre_half();
    check("byp0_comb_old", 2, o1[2], 16'd28);
    check("byp1_comb_new", 0, o1[0], 16'd15);
    post_half();
    check("byp0_reg_old", 3, o1[3], 16'd28);
    check("byp1_reg_new", 1, o1[1], 16'd15);
    check("byp0_comb_after", 2, o1[2], 16'd15);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle();
    check("byp0_reg_later", 3, o1[3], 16'd15);

    // Zero register: both ports write address 0 with different data.
    apply(0, 1, 0, 'hAA, 1, 0, 'h55, 0, 0);
    pre_half();
    check("zero_bypass", 4, o1[4], 16'd0);
    check("nozero_bypass", 0, o1[0], 16'h55);
    post_half();
    check("zero_conflict", 4, 16'(cf[4]), 16'd0);
    check("nozero_conflict", 0, 16'(cf[0]), 16'd1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    pre_half();
    check("zero_read", 4, o1[4], 16'd0);
    check("nozero_read", 0, o1[0], 16'h55);
    post_half();

    // Wide configuration: top and bottom registers in one dual-port write.
    apply(0, 1, 15, 'hBEEF, 1, 0, 'h1234, 15, 0);
    cycle();
    check("wide_fwd15", 5, o1[5], 16'hBEEF);
    check("wide_fwd0", 5, o2[5], 16'h1234);
    apply(0, 0, 0, 0, 0, 0, 0, 15, 0);
    cycle();
    check("wide_rd15", 5, o1[5], 16'hBEEF);
    check("wide_rd0", 5, o2[5], 16'h1234);

    // Random dual-port traffic with biased address collisions and rare resets.
    for (int n = 0; n < 1000; n++) begin
      logic [3:0] x1, x2;
      x1 = 4'($urandom_range(0, 15));
      x2 = ($urandom_range(0, 3) == 0) ? x1 : 4'($urandom_range(0, 15));
      apply(($urandom_range(0, 63) == 0) ? 1 : 0,
            int'($urandom_range(0, 1)), int'(x1), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 1)), int'(x2), int'($urandom_range(0, 65535)),
            ($urandom_range(0, 1) == 0) ? int'(x1) : int'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 0) ? int'(x2) : int'($urandom_range(0, 15)));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_reg_file_2w2r
